// File: rtl/mem_port_arbiter.sv
// Arbitrates one 64-bit memory port between instruction fetch and data load/store, one transaction in flight.
// Optional ARB_FAIRNESS_EN bounds how many D grants IF can lose in a row (limit MAX_WAIT).
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [7:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
    end

    state_t            state;
    state_t            state_next;
    owner_t            owner;

    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [7:0]        hold_be;

    logic              arb_idle;
    logic              force_if;

`ifdef ARB_FAIRNESS_EN
    logic [3:0] wait_cnt;

    // Once D has won MAX_WAIT times against a waiting fetch, the fetch gets the next slot.
    assign force_if = if_req && (wait_cnt == 4'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (if_gnt) begin
            wait_cnt <= 4'd0;
        end else if (d_gnt && if_req) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else if (state == IDLE && !if_req) begin
            wait_cnt <= 4'd0;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are combinational and only offered in IDLE outside reset.
    assign arb_idle = (state == IDLE) && !rst;
    assign d_gnt    = arb_idle && d_req && !force_if;
    assign if_gnt   = arb_idle && if_req && !d_gnt;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_gnt || if_gnt) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The memory side sees only the holding registers, so it stays stable while mem_gnt is withheld.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_IF;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= 8'h00;
        end else if (d_gnt) begin
            owner      <= OWN_D;
            hold_we    <= d_we;
            hold_addr  <= d_addr;
            hold_wdata <= d_wdata;
            hold_be    <= d_be;
        end else if (if_gnt) begin
            owner      <= OWN_IF;
            hold_we    <= 1'b0;
            hold_addr  <= if_addr;
            hold_wdata <= '0;
            hold_be    <= 8'hFF;
        end
    end

    // A response arriving when none is expected (including alongside mem_gnt in ISSUE) latches err.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mem_rvalid && state != WAIT_RESP) begin
            err <= 1'b1;
        end
    end

    assign mem_req   = (state == ISSUE);
    assign mem_we    = hold_we;
    assign mem_addr  = hold_addr;
    assign mem_wdata = hold_wdata;
    assign mem_be    = hold_be;

    assign if_rvalid = (state == WAIT_RESP) && mem_rvalid && (owner == OWN_IF);
    assign d_rvalid  = (state == WAIT_RESP) && mem_rvalid && (owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change just after negedge, outputs checked 1 ns later.
// Grant-order expectations switch on ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_d;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Move to the next cycle's drive point (just after negedge).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 8'h00;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) next_cycle();
        settle();
        check_output("rst_busy", busy, 0);
        check_output("rst_mem_req", mem_req, 0);
        check_output("rst_err", err, 0);
        check_output("rst_mem_be", mem_be, 0);
        check_output("rst_mem_addr", mem_addr, 0);

        // Single fetch
        next_cycle(); rst = 1'b0; if_req = 1'b1; if_addr = 64'h100; settle();
        check_output("f_if_gnt", if_gnt, 1);
        check_output("f_d_gnt", d_gnt, 0);
        check_output("f_busy_n", busy, 0);
        next_cycle(); if_req = 1'b0; mem_gnt = 1'b1; settle();
        check_output("f_mem_req", mem_req, 1);
        check_output("f_mem_addr", mem_addr, 64'h100);
        check_output("f_mem_be", mem_be, 8'hFF);
        check_output("f_mem_we", mem_we, 0);
        check_output("f_busy", busy, 1);
        next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h13; settle();
        check_output("f_if_rvalid", if_rvalid, 1);
        check_output("f_if_rdata", if_rdata, 64'h13);
        check_output("f_d_rvalid", d_rvalid, 0);
        check_output("f_mem_req_drop", mem_req, 0);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("f_busy_end", busy, 0);
        check_output("f_err", err, 0);

        // Simultaneous IF and D store: D first
        next_cycle(); if_req = 1'b1; if_addr = 64'h108;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wdata = 64'hDEADBEEF; d_be = 8'h0F; settle();
        check_output("s_d_gnt", d_gnt, 1);
        check_output("s_if_gnt", if_gnt, 0);
        next_cycle(); d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h0; d_be = 8'h00; mem_gnt = 1'b1; settle();
        check_output("s_mem_req", mem_req, 1);
        check_output("s_mem_we", mem_we, 1);
        check_output("s_mem_be", mem_be, 8'h0F);
        check_output("s_mem_addr", mem_addr, 64'h2000);
        check_output("s_mem_wdata", mem_wdata, 64'hDEADBEEF);
        check_output("s_if_gnt_issue", if_gnt, 0);
        next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h55; settle();
        check_output("s_d_rvalid", d_rvalid, 1);
        check_output("s_if_rvalid", if_rvalid, 0);
        check_output("s_if_gnt_wait", if_gnt, 0);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("s_if_gnt_idle", if_gnt, 1);
        check_output("s_d_gnt_idle", d_gnt, 0);
        next_cycle(); if_req = 1'b0; mem_gnt = 1'b1; settle();
        check_output("s_if_mem_addr", mem_addr, 64'h108);
        check_output("s_if_mem_we", mem_we, 0);
        check_output("s_if_mem_be", mem_be, 8'hFF);
        next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAB; settle();
        check_output("s_if_rvalid2", if_rvalid, 1);
        check_output("s_d_rvalid2", d_rvalid, 0);
        check_output("s_if_rdata2", if_rdata, 64'hAB);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("s_busy_end", busy, 0);

        // D load under memory backpressure
        next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3008; d_be = 8'hFF; settle();
        check_output("b_d_gnt", d_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); d_req = 1'b0; d_addr = 64'hFFFF; if_req = 1'b1; if_addr = 64'h500; settle();
            check_output("b_mem_req", mem_req, 1);
            check_output("b_mem_addr", mem_addr, 64'h3008);
            check_output("b_mem_we", mem_we, 0);
            check_output("b_if_gnt", if_gnt, 0);
            check_output("b_d_rvalid", d_rvalid, 0);
        end
        next_cycle(); if_req = 1'b0; mem_gnt = 1'b1; settle();
        check_output("b_mem_req_gnt", mem_req, 1);
        next_cycle(); mem_gnt = 1'b0; settle();
        check_output("b_wait_mem_req", mem_req, 0);
        check_output("b_wait_d_rvalid", d_rvalid, 0);
        next_cycle(); mem_rvalid = 1'b1; mem_rdata = 64'h1122334455667788; settle();
        check_output("b_d_rvalid_resp", d_rvalid, 1);
        check_output("b_d_rdata", d_rdata, 64'h1122334455667788);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("b_busy_end", busy, 0);
        check_output("b_err", err, 0);

        // Reset during WAIT_RESP
        next_cycle(); d_req = 1'b1; d_addr = 64'h4000; settle();
        check_output("r_d_gnt", d_gnt, 1);
        next_cycle(); d_req = 1'b0; mem_gnt = 1'b1; settle();
        check_output("r_mem_req", mem_req, 1);
        next_cycle(); mem_gnt = 1'b0; rst = 1'b1; settle();
        check_output("r_busy_wait", busy, 1);
        next_cycle(); rst = 1'b0; settle();
        check_output("r_busy_after", busy, 0);
        check_output("r_mem_req_after", mem_req, 0);
        next_cycle(); mem_rvalid = 1'b1; mem_rdata = 64'h77; settle();
        check_output("r_late_d_rvalid", d_rvalid, 0);
        check_output("r_late_if_rvalid", if_rvalid, 0);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("r_err_set", err, 1);
        next_cycle(); settle();
        check_output("r_err_sticky", err, 1);
        pulse_reset(); settle();
        check_output("r_err_clear", err, 0);

        // Spurious response in IDLE
        next_cycle(); mem_rvalid = 1'b1; settle();
        check_output("x_if_rvalid", if_rvalid, 0);
        check_output("x_d_rvalid", d_rvalid, 0);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("x_err_set", err, 1);
        repeat (3) next_cycle();
        settle();
        check_output("x_err_sticky", err, 1);
        pulse_reset(); settle();
        check_output("x_err_clear", err, 0);

        // mem_gnt and mem_rvalid together in ISSUE
        next_cycle(); if_req = 1'b1; if_addr = 64'h200; settle();
        check_output("g_if_gnt", if_gnt, 1);
        next_cycle(); if_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; settle();
        check_output("g_if_rvalid_issue", if_rvalid, 0);
        next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b0; settle();
        check_output("g_busy", busy, 1);
        check_output("g_mem_req", mem_req, 0);
        check_output("g_err", err, 1);
        next_cycle(); mem_rvalid = 1'b1; mem_rdata = 64'h99; settle();
        check_output("g_if_rvalid", if_rvalid, 1);
        check_output("g_if_rdata", if_rdata, 64'h99);
        next_cycle(); mem_rvalid = 1'b0; settle();
        check_output("g_busy_end", busy, 0);
        pulse_reset();

        // Continuous contention: grant order
        for (int t = 0; t < 6; t++) begin
`ifdef ARB_FAIRNESS_EN
            exp_d = (t != 4);
`else
            exp_d = 1'b1;
`endif
            next_cycle(); d_req = 1'b1; if_req = 1'b1; d_we = 1'b0; d_addr = 64'h6000; if_addr = 64'h700;
            mem_gnt = 1'b1; mem_rvalid = 1'b0; settle();
            check_output("c_d_gnt", d_gnt, exp_d);
            check_output("c_if_gnt", if_gnt, !exp_d);
            next_cycle(); settle();
            next_cycle(); mem_rvalid = 1'b1; settle();
            check_output("c_rvalid_owner", d_rvalid, exp_d);
        end
        next_cycle(); d_req = 1'b0; if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; settle();
        check_output("c_busy_end", busy, 0);
        check_output("c_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
